// File: rtl/ctrl_pkg.sv
// Shared opcodes, state encoding and decoded-field bundle for the
// multi-cycle RV32I control unit.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] IR_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH   = 3'b000,
        S_DECODE  = 3'b001,
        S_EXECUTE = 3'b010,
        S_MEM     = 3'b011,
        S_WB      = 3'b100,
        S_TRAP    = 3'b101
    } state_t;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    typedef struct packed {
        logic [2:0] immsel;
        logic [3:0] alusel;
        logic       src1;
        logic       src2;
        logic       brun;
        logic [2:0] ldu;
        logic [1:0] wbsel;
        logic       memrw;
        logic       is_wb;
        logic       is_jump;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
    } dec_t;

    // funct3[2] picks the less-than compare, funct3[0] inverts it
    function automatic logic br_taken(
        input logic [2:0] f3,
        input logic       breq,
        input logic       brlt
    );
        return f3[2] ? (brlt ^ f3[0]) : (breq ^ f3[0]);
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational field decode of the latched instruction register.
// Fields not meaningful for an opcode stay at their idle values.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);

    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b;
    logic       unused_ir;

    assign op  = ir[6:0];
    assign f3  = ir[14:12];
    assign f7b = ir[30];
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

    always_comb begin
        dec        = '0;
        dec.immsel = IMM_I;
        dec.alusel = ALU_ADD;
        dec.wbsel  = WB_ALU;
        unique case (1'b1)
            op == OP_R: begin
                dec.alusel = {f7b, f3};
                dec.is_wb  = 1'b1;
            end
            op == OP_I: begin
                dec.alusel = {(f3 == 3'b101) & f7b, f3};
                dec.src2   = 1'b1;
                dec.is_wb  = 1'b1;
            end
            op == OP_LOAD: begin
                dec.src2    = 1'b1;
                dec.ldu     = f3;
                dec.wbsel   = WB_MEM;
                dec.is_load = 1'b1;
            end
            op == OP_STORE: begin
                dec.immsel   = IMM_S;
                dec.src2     = 1'b1;
                dec.memrw    = 1'b1;
                dec.is_store = 1'b1;
            end
            op == OP_BRANCH: begin
                dec.immsel    = IMM_B;
                dec.src1      = 1'b1;
                dec.src2      = 1'b1;
                dec.brun      = f3[1];
                dec.is_branch = 1'b1;
            end
            op == OP_LUI: begin
                dec.immsel = IMM_U;
                dec.alusel = ALU_PASSB;
                dec.src2   = 1'b1;
                dec.is_wb  = 1'b1;
            end
            op == OP_AUIPC: begin
                dec.immsel = IMM_U;
                dec.src1   = 1'b1;
                dec.src2   = 1'b1;
                dec.is_wb  = 1'b1;
            end
            op == OP_JAL: begin
                dec.immsel  = IMM_J;
                dec.src1    = 1'b1;
                dec.src2    = 1'b1;
                dec.wbsel   = WB_PC4;
                dec.is_wb   = 1'b1;
                dec.is_jump = 1'b1;
            end
            op == OP_JALR: begin
                dec.src2    = 1'b1;
                dec.wbsel   = WB_PC4;
                dec.is_wb   = 1'b1;
                dec.is_jump = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB/TRAP.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instr,
    input  logic            instr_valid,
    input  logic            BrEq,
    input  logic            BrLT,
    input  logic            mem_ready,
    output logic            IRWEn,
    output logic            PCWEn,
    output logic            PCSel,
    output logic            RegWEn,
    output logic [2:0]      ImmSel,
    output logic [3:0]      AluSEL,
    output logic            ALUsrc1,
    output logic            ALUsrc2,
    output logic            BrUn,
    output logic            MemReq,
    output logic            MemRw,
    output logic [2:0]      ldU,
    output logic [1:0]      WBSel,
    output logic [2:0]      state,
    output logic            illegal,
    output logic            mem_err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] ir;
    logic            ir_ok;
    logic [CW-1:0]   cnt;
    logic            illegal_q;
    logic            mem_err_q;
    logic            set_ill;
    logic            set_merr;
    logic            cnt_inc;
    dec_t            dec_raw;
    dec_t            dec;

    ctrl_decode u_decode (
        .ir  (ir),
        .dec (dec_raw)
    );

    // Until the first fetch the reset NOP is shown as idle fields
    always_comb begin
        dec = dec_raw;
        if (!ir_ok) begin
            dec       = '0;
            dec.wbsel = WB_ALU;
        end
    end

    always_comb begin
        state_d  = state_q;
        IRWEn    = 1'b0;
        PCWEn    = 1'b0;
        PCSel    = 1'b0;
        RegWEn   = 1'b0;
        MemReq   = 1'b0;
        set_ill  = 1'b0;
        set_merr = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (instr_valid && rst_n) begin
                    IRWEn   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                unique case (1'b1)
                    dec.is_branch: begin
                        PCWEn   = 1'b1;
                        PCSel   = br_taken(ir[14:12], BrEq, BrLT);
                        state_d = S_FETCH;
                    end
                    dec.is_load | dec.is_store: state_d = S_MEM;
                    dec.is_wb: state_d = S_WB;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        set_ill = 1'b1;
                        state_d = S_TRAP;
`else
                        PCWEn   = 1'b1;
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                MemReq = 1'b1;
                if (mem_ready) begin
                    if (dec.is_load) begin
                        state_d = S_WB;
                    end else begin
                        PCWEn   = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (cnt == CNT_LAST) begin
                    set_merr = 1'b1;
                    state_d  = S_TRAP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_WB: begin
                RegWEn  = 1'b1;
                PCWEn   = 1'b1;
                PCSel   = dec.is_jump;
                state_d = S_FETCH;
            end
            S_TRAP: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir        <= IR_NOP;
            ir_ok     <= 1'b0;
            cnt       <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (IRWEn) begin
                ir    <= instr;
                ir_ok <= 1'b1;
            end
            if (state_d != S_MEM) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            illegal_q <= illegal_q | set_ill;
            mem_err_q <= mem_err_q | set_merr;
        end
    end

    assign ImmSel  = dec.immsel;
    assign AluSEL  = dec.alusel;
    assign ALUsrc1 = dec.src1;
    assign ALUsrc2 = dec.src2;
    assign BrUn    = dec.brun;
    assign ldU     = dec.ldu;
    assign WBSel   = dec.wbsel;
    assign MemRw   = dec.memrw;
    assign state   = state_q;
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, corner sequences and
// random instructions checked against a per-instruction cycle model.
module tb_multicycle_control;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        BrEq;
    logic        BrLT;
    logic        mem_ready;
    logic        IRWEn;
    logic        PCWEn;
    logic        PCSel;
    logic        RegWEn;
    logic [2:0]  ImmSel;
    logic [3:0]  AluSEL;
    logic        ALUsrc1;
    logic        ALUsrc2;
    logic        BrUn;
    logic        MemReq;
    logic        MemRw;
    logic [2:0]  ldU;
    logic [1:0]  WBSel;
    logic [2:0]  state;
    logic        illegal;
    logic        mem_err;

    always #5 clk = ~clk;

    multicycle_control #(.XLEN(32), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .instr_valid(instr_valid), .BrEq(BrEq), .BrLT(BrLT),
        .mem_ready(mem_ready), .IRWEn(IRWEn), .PCWEn(PCWEn),
        .PCSel(PCSel), .RegWEn(RegWEn), .ImmSel(ImmSel),
        .AluSEL(AluSEL), .ALUsrc1(ALUsrc1), .ALUsrc2(ALUsrc2),
        .BrUn(BrUn), .MemReq(MemReq), .MemRw(MemRw), .ldU(ldU),
        .WBSel(WBSel), .state(state), .illegal(illegal),
        .mem_err(mem_err)
    );

    typedef struct packed {
        logic [2:0] immsel;
        logic [3:0] alusel;
        logic       src1;
        logic       src2;
        logic       brun;
        logic [2:0] ldu;
        logic [1:0] wbsel;
        logic       memrw;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        breq;
        logic        brlt;
        int          waits;
        exp_t        e;
    } vec_t;

    typedef enum {K_ALU, K_JUMP, K_LOAD, K_STORE, K_BRANCH, K_BAD} kind_t;

    int   nvec = 0;
    int   nerr = 0;
    exp_t dutf;
    vec_t tbl[17];

    assign dutf = {ImmSel, AluSEL, ALUsrc1, ALUsrc2, BrUn, ldU, WBSel, MemRw};

    function automatic exp_t mk(input int imm, input int alu, input int s1,
                                input int s2, input int bu, input int ld,
                                input int wb, input int rw);
        exp_t e;
        e.immsel = imm[2:0];
        e.alusel = alu[3:0];
        e.src1   = s1[0];
        e.src2   = s2[0];
        e.brun   = bu[0];
        e.ldu    = ld[2:0];
        e.wbsel  = wb[1:0];
        e.memrw  = rw[0];
        return e;
    endfunction

    function automatic kind_t kind_of(input logic [31:0] i);
        case (i[6:0])
            7'h33, 7'h13, 7'h37, 7'h17: return K_ALU;
            7'h6F, 7'h67: return K_JUMP;
            7'h03: return K_LOAD;
            7'h23: return K_STORE;
            7'h63: return K_BRANCH;
            default: return K_BAD;
        endcase
    endfunction

    // Reference decode straight from the instruction-format tables
    function automatic exp_t model(input logic [31:0] i);
        exp_t       e;
        logic [2:0] f3;
        f3 = i[14:12];
        e  = mk(0, 0, 0, 0, 0, 0, 1, 0);
        case (i[6:0])
            7'h33: e.alusel = {i[30], f3};
            7'h13: begin
                e.alusel = {(f3 == 3'b101) && i[30], f3};
                e.src2   = 1'b1;
            end
            7'h03: begin e.src2 = 1'b1; e.ldu = f3; e.wbsel = 2'b00; end
            7'h23: begin e.immsel = 3'd1; e.src2 = 1'b1; e.memrw = 1'b1; end
            7'h63: begin
                e.immsel = 3'd2; e.src1 = 1'b1; e.src2 = 1'b1;
                e.brun = f3[1];
            end
            7'h37: begin e.immsel = 3'd3; e.alusel = 4'hF; e.src2 = 1'b1; end
            7'h17: begin e.immsel = 3'd3; e.src1 = 1'b1; e.src2 = 1'b1; end
            7'h6F: begin
                e.immsel = 3'd4; e.src1 = 1'b1; e.src2 = 1'b1;
                e.wbsel = 2'b10;
            end
            7'h67: begin e.src2 = 1'b1; e.wbsel = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit taken(input logic [2:0] f3, input logic eq,
                                 input logic lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Caller sits just after a falling edge
    task automatic do_reset();
        rst_n = 1'b0;
        instr_valid = 1'b1;
        instr = $urandom;
        mem_ready = 1'b1;
        #1;
        check("rst_state", state, 0);
        check("rst_en", {IRWEn, PCWEn, RegWEn, MemReq, PCSel}, 0);
        check("rst_flags", {illegal, mem_err}, 0);
        check("rst_fields", dutf, mk(0, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        rst_n = 1'b1;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rst_exit", {state, IRWEn, PCWEn, RegWEn, MemReq}, 0);
    endtask

    task automatic run_instr(input logic [31:0] i, input logic bq,
                             input logic bl, input int waits,
                             input exp_t e);
        kind_t k;
        int    st[$];
        bit    mtrap;
        bit    itrap;
        bit    exp_pc;
        bit    pcw;
        int    mc;
        k = kind_of(i);
        mtrap = 0;
        itrap = 0;
        mc = 0;
        st = {0, 1, 2};
        case (k)
            K_ALU, K_JUMP: st.push_back(4);
            K_LOAD, K_STORE: begin
                if (waits >= TMO) begin
                    repeat (TMO) st.push_back(3);
                    mtrap = 1;
                end else begin
                    repeat (waits + 1) st.push_back(3);
                    if (k == K_LOAD) st.push_back(4);
                end
            end
            K_BAD: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                itrap = 1;
`endif
            end
            default: ;
        endcase
        exp_pc = (k == K_BRANCH) ? taken(i[14:12], bq, bl) : (k == K_JUMP);
        for (int c = 0; c < st.size(); c++) begin
            @(negedge clk);
            instr_valid = (c == 0);
            instr = (c == 0) ? i : $urandom;
            BrEq = bq;
            BrLT = bl;
            mem_ready = 1'b0;
            if (st[c] == 3) begin
                mem_ready = (mc == waits);
                mc++;
            end
            #1;
            pcw = !(mtrap || itrap) && (c == st.size() - 1);
            check("state", state, st[c]);
            check("IRWEn", IRWEn, c == 0);
            check("PCWEn", PCWEn, pcw);
            check("RegWEn", RegWEn, st[c] == 4);
            check("MemReq", MemReq, st[c] == 3);
            if (pcw) check("PCSel", PCSel, exp_pc);
            if (c > 0) check("fields", dutf, e);
            check("flags", {illegal, mem_err}, 0);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        #1;
        if (mtrap || itrap) begin
            check("trap_state", state, 5);
            check("trap_flags", {illegal, mem_err}, {itrap, mtrap});
            check("trap_en", {IRWEn, PCWEn, RegWEn, MemReq}, 0);
            @(negedge clk);
            #1;
            check("trap_hold", state, 5);
            @(negedge clk);
            do_reset();
        end else begin
            check("return", {state, IRWEn, PCWEn, RegWEn, MemReq}, 0);
        end
    endtask

    logic [31:0] ri;
    logic [2:0]  bf3[6];
    logic [6:0]  bad_ops[4];
    logic [6:0]  rop;
    int          rw;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        instr = '0;
        instr_valid = 1'b0;
        BrEq = 1'b0;
        BrLT = 1'b0;
        mem_ready = 1'b0;
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        bad_ops = '{7'h7F, 7'h0F, 7'h73, 7'h00};

        tbl[0]  = '{32'h00400793, 0, 0, 0,  mk(0, 0, 0, 1, 0, 0, 1, 0)};
        tbl[1]  = '{32'h40C58533, 0, 0, 0,  mk(0, 8, 0, 0, 0, 0, 1, 0)};
        tbl[2]  = '{32'hfef42623, 0, 0, 2,  mk(1, 0, 0, 1, 0, 0, 1, 1)};
        tbl[3]  = '{32'h00462503, 0, 0, 0,  mk(0, 0, 0, 1, 0, 2, 0, 0)};
        tbl[4]  = '{32'h00058663, 1, 0, 0,  mk(2, 0, 1, 1, 0, 0, 1, 0)};
        tbl[5]  = '{32'h00058663, 0, 1, 0,  mk(2, 0, 1, 1, 0, 0, 1, 0)};
        tbl[6]  = '{32'h0020E063, 0, 1, 0,  mk(2, 0, 1, 1, 1, 0, 1, 0)};
        tbl[7]  = '{32'h0020D063, 1, 1, 0,  mk(2, 0, 1, 1, 0, 0, 1, 0)};
        tbl[8]  = '{32'h000000EF, 0, 0, 0,  mk(4, 0, 1, 1, 0, 0, 2, 0)};
        tbl[9]  = '{32'h000080E7, 0, 0, 0,  mk(0, 0, 0, 1, 0, 0, 2, 0)};
        tbl[10] = '{32'h123450B7, 0, 0, 0,  mk(3, 15, 0, 1, 0, 0, 1, 0)};
        tbl[11] = '{32'h00001097, 0, 0, 0,  mk(3, 0, 1, 1, 0, 0, 1, 0)};
        tbl[12] = '{32'h4030D093, 0, 0, 0,  mk(0, 13, 0, 1, 0, 0, 1, 0)};
        tbl[13] = '{32'h40000093, 0, 0, 0,  mk(0, 0, 0, 1, 0, 0, 1, 0)};
        tbl[14] = '{32'hfef42623, 0, 0, 14, mk(1, 0, 0, 1, 0, 0, 1, 1)};
        tbl[15] = '{32'h00462503, 0, 0, 15, mk(0, 0, 0, 1, 0, 2, 0, 0)};
        tbl[16] = '{32'hFFFFFFFF, 0, 0, 0,  mk(0, 0, 0, 0, 0, 0, 1, 0)};

        @(negedge clk);
        do_reset();

        // FETCH holds while imem is not ready
        repeat (2) begin
            @(negedge clk);
            instr_valid = 1'b0;
            #1;
            check("fetch_hold", {state, IRWEn, PCWEn}, 0);
        end

        for (int n = 0; n < 17; n++)
            run_instr(tbl[n].instr, tbl[n].breq, tbl[n].brlt,
                      tbl[n].waits, tbl[n].e);

        // Reset while a load is waiting in MEM aborts it
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 32'h00462503;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("mid_mem", {state, MemReq}, {3'd3, 1'b1});
        do_reset();

        for (int n = 0; n < 200; n++) begin
            ri = $urandom;
            case ($urandom_range(0, 9))
                0: rop = 7'h33;
                1: rop = 7'h13;
                2: rop = 7'h37;
                3: rop = 7'h17;
                4: rop = 7'h6F;
                5: rop = 7'h67;
                6: rop = 7'h03;
                7: rop = 7'h23;
                8: rop = 7'h63;
                default: rop = bad_ops[$urandom_range(0, 3)];
            endcase
            ri[6:0] = rop;
            if (rop == 7'h63) ri[14:12] = bf3[$urandom_range(0, 5)];
            rw = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) rw = TMO;
            run_instr(ri, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), rw, model(ri));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
